// File: rtl/main_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS-16 main control FSM:
// opcodes, function codes, state encoding and datapath select encodings.
package main_ctrl_fsm_pkg;

    localparam int IW     = 16;
    localparam int JUMP_W = 12;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_ANDI  = 4'b0010;
    localparam logic [3:0] OP_ORI   = 4'b0011;
    localparam logic [3:0] OP_SUBI  = 4'b0100;
    localparam logic [3:0] OP_LOAD  = 4'b0111;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_BEQ   = 4'b1001;
    localparam logic [3:0] OP_BNE   = 4'b1010;
    localparam logic [3:0] OP_BLT   = 4'b1011;
    localparam logic [3:0] OP_BGT   = 4'b1100;
    localparam logic [3:0] OP_JUMP  = 4'b1101;

    localparam logic [2:0] FUNC_ILLEGAL = 3'b111;

    localparam logic [1:0] ASB_RT  = 2'b00;
    localparam logic [1:0] ASB_ONE = 2'b01;
    localparam logic [1:0] ASB_IMM = 2'b10;

    localparam logic [1:0] PC_ALU = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11
    } state_e;

    // Dispatch target out of S_DECODE for a given opcode/func pair.
    function automatic state_e decode_next(input logic [3:0] op,
                                           input logic [2:0] fn);
        state_e s;
        s = S_HALT;
        case (op)
            OP_RTYPE: s = (fn == FUNC_ILLEGAL) ? S_HALT : S_EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SUBI: s = S_EXEC_I;
            OP_LOAD, OP_STORE: s = S_MEM_ADDR;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGT: s = S_BRANCH;
            OP_JUMP: s = S_JUMP;
            default: s = S_HALT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/main_ctrl_fsm_instr_reg.sv
// Instruction register: loads on the fetch strobe, clears on reset,
// and exposes the decoded instruction fields.
module main_ctrl_fsm_instr_reg
    import main_ctrl_fsm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic [IW-1:0]     din,
    output logic [3:0]        opcode,
    output logic [2:0]        rs,
    output logic [2:0]        rt,
    output logic [2:0]        rd,
    output logic [2:0]        func,
    output logic [5:0]        imm,
    output logic [JUMP_W-1:0] jtarget
);

    logic [IW-1:0] ir_q;
    logic [IW-1:0] ir_d;

    always_comb begin
        ir_d = ir_q;
        if (ld) begin
            ir_d = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

    assign opcode  = ir_q[15:12];
    assign rs      = ir_q[11:9];
    assign rt      = ir_q[8:6];
    assign rd      = ir_q[5:3];
    assign func    = ir_q[2:0];
    assign imm     = ir_q[5:0];
    assign jtarget = ir_q[JUMP_W-1:0];

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multi-cycle main control FSM of the 16-bit MIPS datapath: sequences
// fetch/decode/execute/memory/writeback and drives every datapath strobe.
module main_ctrl_fsm
    import main_ctrl_fsm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IW-1:0]     mem_rdata,
    input  logic              mem_ready,
    input  logic              alu_cond,
    output logic [3:0]        opcode,
    output logic [2:0]        func,
    output logic [2:0]        rs,
    output logic [2:0]        rt,
    output logic [2:0]        rd,
    output logic [5:0]        imm,
    output logic [JUMP_W-1:0] jtarget,
    output logic              mem_read,
    output logic              mem_write,
    output logic              i_or_d,
    output logic              ir_write,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              halt
);

    state_e state_q;
    state_e state_d;

    // Clear while reset is held so that no request is presented; the
    // first fetch starts on the clock edge after reset is released.
    logic run_q;
    logic run_d;

    main_ctrl_fsm_instr_reg u_ir (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (ir_write),
        .din     (mem_rdata),
        .opcode  (opcode),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .func    (func),
        .imm     (imm),
        .jtarget (jtarget)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = 1'b1;
        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        state_d = S_DECODE;
                    end
                end
                S_DECODE:   state_d = decode_next(opcode, func);
                S_EXEC_R:   state_d = S_WB_ALU;
                S_EXEC_I:   state_d = S_WB_ALU;
                S_MEM_ADDR: begin
                    state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    if (mem_ready) begin
                        state_d = S_WB_MEM;
                    end
                end
                S_MEM_WR: begin
                    if (mem_ready) begin
                        state_d = S_FETCH;
                    end
                end
                S_WB_ALU:   state_d = S_FETCH;
                S_WB_MEM:   state_d = S_FETCH;
                S_BRANCH:   state_d = S_FETCH;
                S_JUMP:     state_d = S_FETCH;
                S_HALT:     state_d = S_HALT;
                default:    state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ASB_RT;
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        halt       = 1'b0;
        if (run_q) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = ASB_ONE;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = ASB_IMM;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                end
                S_EXEC_I, S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ASB_IMM;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    reg_dst   = (opcode == OP_RTYPE);
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    pc_src    = PC_BR;
                    pc_write  = alu_cond;
                end
                S_JUMP: begin
                    pc_src   = PC_JMP;
                    pc_write = 1'b1;
                end
                S_HALT: begin
                    halt = 1'b1;
                end
                default: begin
                    halt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Self-checking bench for main_ctrl_fsm: directed scenarios plus random
// instructions scored against an instruction-level latency/strobe model.
module tb_main_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        alu_cond;
    logic [3:0]  opcode;
    logic [2:0]  func;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [5:0]  imm;
    logic [11:0] jtarget;
    logic        mem_read;
    logic        mem_write;
    logic        i_or_d;
    logic        ir_write;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        halt;

    int ncmp = 0;
    int nfail = 0;

    localparam int C_R  = 0;
    localparam int C_I  = 1;
    localparam int C_LD = 2;
    localparam int C_ST = 3;
    localparam int C_BR = 4;
    localparam int C_J  = 5;
    localparam int C_IL = 6;

    main_ctrl_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .alu_cond   (alu_cond),
        .opcode     (opcode),
        .func       (func),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm        (imm),
        .jtarget    (jtarget),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .halt       (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cls_of(input logic [15:0] ins);
        logic [3:0] op;
        logic [2:0] fn;
        op = ins[15:12];
        fn = ins[2:0];
        if (op == 4'd0) return (fn == 3'd7) ? C_IL : C_R;
        if (op >= 4'd1 && op <= 4'd4) return C_I;
        if (op == 4'd7) return C_LD;
        if (op == 4'd8) return C_ST;
        if (op >= 4'd9 && op <= 4'd12) return C_BR;
        if (op == 4'd13) return C_J;
        return C_IL;
    endfunction

    function automatic logic any_strobe();
        return mem_read | mem_write | ir_write | reg_write | pc_write |
               i_or_d | reg_dst | mem_to_reg | alu_src_a |
               (|alu_src_b) | (|pc_src);
    endfunction

    // One legal instruction from its first fetch cycle to its last cycle.
    task automatic run_instr(input logic [15:0] ins, input int fw,
                             input int mw, input logic cond);
        int cls;
        int exp_cyc;
        int e_rd, e_wr, e_rw, e_pw, e_rw_at, e_pw_at;
        int n_rd, n_wr, n_rw, n_pw, n_ir, rw_at, pw_at, bad;
        int fwl, mwl;
        bit fetched, in_mem;
        cls = cls_of(ins);
        exp_cyc = fw;
        case (cls)
            C_LD:    exp_cyc += 5 + mw;
            C_ST:    exp_cyc += 4 + mw;
            C_BR:    exp_cyc += 3;
            C_J:     exp_cyc += 3;
            default: exp_cyc += 4;
        endcase
        e_rd = fw + 1 + ((cls == C_LD) ? mw + 1 : 0);
        e_wr = (cls == C_ST) ? mw + 1 : 0;
        e_rw = (cls == C_R || cls == C_I || cls == C_LD) ? 1 : 0;
        e_pw = 1 + ((cls == C_J || (cls == C_BR && cond)) ? 1 : 0);
        e_rw_at = (cls == C_R || cls == C_I) ? 4 + fw :
                  (cls == C_LD) ? 5 + fw + mw : 0;
        e_pw_at = (e_pw == 2) ? 3 + fw : 0;
        n_rd = 0; n_wr = 0; n_rw = 0; n_pw = 0; n_ir = 0;
        rw_at = 0; pw_at = 0; bad = 0;
        fwl = fw; mwl = mw; fetched = 0;
        mem_rdata = ins;
        alu_cond = cond;
        for (int c = 1; c <= exp_cyc; c++) begin
            @(negedge clk);
            in_mem = fetched;
            if (fetched) mem_rdata = 16'($urandom);
            if (mem_read || mem_write) begin
                if (!fetched) begin
                    if (fwl > 0) begin
                        fwl--;
                        mem_ready = 1'b0;
                    end else begin
                        mem_ready = 1'b1;
                        fetched = 1;
                    end
                end else if (mwl > 0) begin
                    mwl--;
                    mem_ready = 1'b0;
                end else begin
                    mem_ready = 1'b1;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (c == 1) begin
                chk("fetch_sig", {mem_read, i_or_d, alu_src_a, alu_src_b},
                    {1'b1, 1'b0, 1'b0, 2'b01});
            end
            if (mem_read) n_rd++;
            if (mem_write) n_wr++;
            if (ir_write) n_ir++;
            if (mem_read && mem_write) bad++;
            if (reg_write && pc_write) bad++;
            if ((mem_read || mem_write) && (i_or_d !== in_mem)) bad++;
            if (reg_write) begin
                n_rw++;
                rw_at = c;
                chk("wb_sel", {reg_dst, mem_to_reg},
                    {(cls == C_R), (cls == C_LD)});
            end
            if (pc_write) begin
                n_pw++;
                if (!ir_write) begin
                    pw_at = c;
                    chk("pc_src", pc_src, (cls == C_J) ? 2 : 1);
                end
            end
        end
        chk("n_mem_read", n_rd, e_rd);
        chk("n_mem_write", n_wr, e_wr);
        chk("n_ir_write", n_ir, 1);
        chk("n_reg_write", n_rw, e_rw);
        chk("n_pc_write", n_pw, e_pw);
        chk("reg_write_cyc", rw_at, e_rw_at);
        chk("pc_write_cyc", pw_at, e_pw_at);
        chk("exclusive", bad, 0);
        chk("ir_fields", {opcode, rs, rt, rd, func},
            {ins[15:12], ins[11:9], ins[8:6], ins[5:3], ins[2:0]});
        chk("imm_jt", {imm, jtarget}, {ins[5:0], ins[11:0]});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rst_strobes", any_strobe(), 0);
        chk("rst_halt", halt, 0);
        chk("rst_ir", {opcode, func, jtarget}, 0);
        @(negedge clk);
        chk("rst_held", any_strobe(), 0);
        rst_n = 1'b1;
    endtask

    // Illegal instruction: halt from cycle fw+3, nothing afterwards.
    task automatic run_halt(input logic [15:0] ins, input int fw);
        int fwl;
        int bad;
        bit fetched;
        fwl = fw; bad = 0; fetched = 0;
        mem_rdata = ins;
        for (int c = 1; c <= fw + 10; c++) begin
            @(negedge clk);
            if (mem_read && !fetched) begin
                if (fwl > 0) begin
                    fwl--;
                    mem_ready = 1'b0;
                end else begin
                    mem_ready = 1'b1;
                    fetched = 1;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            chk("halt_flag", halt, (c >= fw + 3) ? 1 : 0);
            if (c >= fw + 3 && any_strobe()) bad++;
        end
        chk("halt_quiet", bad, 0);
    endtask

    // Reset lands while the store is still waiting on memory.
    task automatic abort_store(input logic [15:0] ins);
        mem_rdata = ins;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            mem_ready = (c == 1);
            #1;
        end
        chk("st_waiting", {mem_write, i_or_d}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("st_abort", {mem_write, mem_read}, 0);
        chk("st_abort_halt", halt, 0);
        @(negedge clk);
        chk("st_abort_held", any_strobe(), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] ins;
        rst_n = 1'b0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        alu_cond = 1'b0;
        #1;
        chk("por_strobes", any_strobe(), 0);
        chk("por_halt", halt, 0);
        do_reset();

        run_instr(16'h0298, 0, 0, 1'b0);
        run_instr(16'h7A4D, 0, 2, 1'b0);
        run_instr(16'h9123, 0, 0, 1'b1);
        run_instr(16'h9123, 1, 0, 1'b0);
        run_instr(16'hDABC, 0, 0, 1'b0);
        run_instr(16'h8155, 2, 1, 1'b0);
        run_instr(16'h2FC1, 1, 0, 1'b1);

        run_halt(16'hE000, 0);
        do_reset();
        run_instr(16'h0298, 0, 0, 1'b0);
        run_halt(16'h03FF, 1);
        do_reset();

        abort_store(16'h8A3F);

        for (int n = 0; n < 60; n++) begin
            do ins = 16'($urandom); while (cls_of(ins) == C_IL);
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("final_fetch", {mem_read, i_or_d, halt}, 3'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
